// File: rtl/mc_core_pkg.sv
// Shared types for the multi-cycle core: opcodes, FSM states, instruction width.
// Latency: n/a (types only).
// Backpressure: n/a.
package mc_core_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_LDI = 3'd4,
        OP_LD  = 3'd5,
        OP_ST  = 3'd6,
        OP_BNZ = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int iw_of(input int raw);
        return 3 + 2 * raw;
    endfunction

endpackage

// File: rtl/mc_branch_lut.sv
// Constant branch-target table indexed by the rb field.
// Latency: combinational.
// Backpressure: none.
module mc_branch_lut #(
    parameter int PCW    = 12,
    parameter int RAW    = 3,
    parameter int ENTRY0 = 0
) (
    input  logic [RAW-1:0] idx,
    output logic [PCW-1:0] tgt
);

    // Entry 0 is the program exit; the rest are spaced 16 words apart.
    always_comb begin
        if (idx == '0)
            tgt = PCW'(ENTRY0);
        else
            tgt = PCW'({idx, 4'b0000});
    end

endmodule

// File: rtl/reg_file.sv
// 2^pw x dw register file, two async read ports, one sync write port.
// Latency: read combinational, write visible the cycle after we.
// Backpressure: none.
module reg_file #(
    parameter int pw = 3,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [pw-1:0] waddr,
    input  logic [dw-1:0] wdata,
    input  logic [pw-1:0] raddr_a,
    output logic [dw-1:0] rdata_a,
    input  logic [pw-1:0] raddr_b,
    output logic [dw-1:0] rdata_b
);

    logic [dw-1:0] regs [2**pw];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**pw; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/mc_core.sv
// Multi-cycle FETCH/EXEC/MEM core over sync instruction and data memories.
// Latency: 2 cycles per ALU/LDI/ST/BNZ instruction, 3 for LD.
// Backpressure: none; memories are assumed to answer the cycle after the address.
module mc_core
    import mc_core_pkg::*;
#(
    parameter int DW       = 8,
    parameter int PCW      = 12,
    parameter int RAW      = 3,
    parameter int START_PC = 0,
    parameter int HALT_PC  = 400,
    parameter int CNTW     = 16,
    localparam int IW      = iw_of(RAW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PCW-1:0]  imem_addr,
    input  logic [IW-1:0]   imem_data,
    output logic [DW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    output logic            dmem_we,
    input  logic [DW-1:0]   dmem_rdata,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] retired
);

    state_t         state;
    logic [PCW-1:0] pc;
    logic [RAW-1:0] mem_dst;

    // imem_data holds the word fetched for the current pc throughout EXEC.
    op_t            op;
    logic [RAW-1:0] ra, rb;
    assign op = op_t'(imem_data[IW-1 -: 3]);
    assign ra = imem_data[2*RAW-1:RAW];
    assign rb = imem_data[RAW-1:0];

    logic [DW-1:0]  rd_a, rd_b, alu_res, rf_wdat;
    logic [RAW-1:0] rf_waddr;
    logic           rf_we;
    logic [PCW-1:0] lut_tgt, pc_nxt;
    logic [CNTW-1:0] retired_inc;

    reg_file #(.pw(RAW), .dw(DW)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdat),
        .raddr_a (ra),
        .rdata_a (rd_a),
        .raddr_b (rb),
        .rdata_b (rd_b)
    );

    mc_branch_lut #(.PCW(PCW), .RAW(RAW), .ENTRY0(HALT_PC)) u_lut (
        .idx (rb),
        .tgt (lut_tgt)
    );

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rd_a + rd_b;
            OP_SUB:  alu_res = rd_a - rd_b;
            OP_AND:  alu_res = rd_a & rd_b;
            OP_XOR:  alu_res = rd_a ^ rd_b;
            OP_LDI:  alu_res = DW'(rb);
            default: alu_res = '0;
        endcase
    end

    assign rf_we    = ((state == S_EXEC) && (op <= OP_LDI)) || (state == S_MEM);
    assign rf_waddr = (state == S_MEM) ? mem_dst : ra;
    assign rf_wdat  = (state == S_MEM) ? dmem_rdata : alu_res;

    assign dmem_we    = (state == S_EXEC) && (op == OP_ST);
    assign dmem_addr  = ((state == S_EXEC) && ((op == OP_LD) || (op == OP_ST))) ? rd_b : '0;
    assign dmem_wdata = dmem_we ? rd_a : '0;

    assign pc_nxt      = ((op == OP_BNZ) && (rd_a != '0)) ? lut_tgt : pc + PCW'(1);
    assign retired_inc = (&retired) ? retired : retired + CNTW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= PCW'(START_PC);
            imem_addr <= PCW'(START_PC);
            mem_dst   <= '0;
            retired   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        pc        <= PCW'(START_PC);
                        imem_addr <= PCW'(START_PC);
                        retired   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (pc == PCW'(HALT_PC)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pc        <= pc_nxt;
                    imem_addr <= pc_nxt;
                    if (op == OP_LD) begin
                        state   <= S_MEM;
                        mem_dst <= ra;
                    end else begin
                        state   <= S_FETCH;
                        retired <= retired_inc;
                    end
                end
                S_MEM: begin
                    state   <= S_FETCH;
                    retired <= retired_inc;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
